// File: rtl/fpu_add_arbiter_pkg.sv
// Shared types and constants for the fpu_add_arbiter slice: FSM state encoding,
// operation codes and the float word layout the shared adder expects.
package fpu_add_arbiter_pkg;

    localparam int FPU_WIDTH    = 32;
    localparam int FPU_EXPONENT = 8;
    localparam int FPU_MANTISSA = 23;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        SEND_A  = 3'd2,
        SEND_B  = 3'd3,
        WAIT_Z  = 3'd4,
        DELIVER = 3'd5
    } state_t;

endpackage

// File: rtl/fpu_add_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found scanning
// last+1, last+2, ... cyclically.
module fpu_add_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the nearest hit to last+1 is written last and wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (req[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one fpu_adder among NUM_REQ requesters: round-robin grant, then an FSM
// walks the adder's get_a / get_b / put_z handshakes and returns the result.
module fpu_add_arbiter
    import fpu_add_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ-1:0]       req_stb,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [WIDTH-1:0]         rsp_z,
    output logic [NUM_REQ-1:0]       rsp_stb,
    input  logic [NUM_REQ-1:0]       rsp_ack,
    output logic [WIDTH-1:0]         fpu_a,
    output logic                     fpu_a_stb,
    input  logic                     fpu_a_ack,
    output logic [WIDTH-1:0]         fpu_b,
    output logic                     fpu_b_stb,
    input  logic                     fpu_b_ack,
    input  logic [WIDTH-1:0]         fpu_z,
    input  logic                     fpu_z_stb,
    output logic                     fpu_z_ack,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx,
    output logic [CNT_W-1:0]         op_count
);

    state_t               state, state_n;
    logic [IDX_W-1:0]     last, last_n, grant_idx_n;
    logic [NUM_REQ-1:0]   req_ack_n, rsp_stb_n;
    logic [WIDTH-1:0]     rsp_z_n, fpu_a_n, fpu_b_n, b_hold, b_hold_n;
    logic                 fpu_a_stb_n, fpu_b_stb_n, fpu_z_ack_n;
    logic [CNT_W-1:0]     op_count_n;
    logic [IDX_W-1:0]     pick;
    logic                 pick_valid;
    logic [WIDTH-1:0]     a_slot [NUM_REQ];
    logic [WIDTH-1:0]     b_slot [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign a_slot[i] = req_a[i*WIDTH +: WIDTH];
        assign b_slot[i] = req_b[i*WIDTH +: WIDTH];
    end

    fpu_add_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_stb),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n     = state;
        last_n      = last;
        grant_idx_n = grant_idx;
        req_ack_n   = req_ack;
        rsp_stb_n   = rsp_stb;
        rsp_z_n     = rsp_z;
        fpu_a_n     = fpu_a;
        fpu_b_n     = fpu_b;
        b_hold_n    = b_hold;
        fpu_a_stb_n = fpu_a_stb;
        fpu_b_stb_n = fpu_b_stb;
        fpu_z_ack_n = fpu_z_ack;
        op_count_n  = op_count;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_n     = pick;
                    req_ack_n       = '0;
                    req_ack_n[pick] = 1'b1;
                    state_n         = ACCEPT;
                end
            end
            ACCEPT: begin
                if (req_stb[grant_idx] && req_ack[grant_idx]) begin
                    fpu_a_n  = a_slot[grant_idx];
                    b_hold_n = b_slot[grant_idx];
                    // Subtract is a + (-b); the sign flip applies to NaN/Inf as well.
                    if (req_op[grant_idx] == OP_SUB) begin
                        b_hold_n[WIDTH-1] = ~b_slot[grant_idx][WIDTH-1];
                    end
                    req_ack_n   = '0;
                    fpu_a_stb_n = 1'b1;
                    state_n     = SEND_A;
                end else if (!req_stb[grant_idx]) begin
                    // Withdrawn before transfer: drop the grant, pointer untouched.
                    req_ack_n = '0;
                    state_n   = IDLE;
                end
            end
            SEND_A: begin
                if (fpu_a_stb && fpu_a_ack) begin
                    fpu_a_stb_n = 1'b0;
                    fpu_b_n     = b_hold;
                    fpu_b_stb_n = 1'b1;
                    state_n     = SEND_B;
                end
            end
            SEND_B: begin
                if (fpu_b_stb && fpu_b_ack) begin
                    fpu_b_stb_n = 1'b0;
                    fpu_z_ack_n = 1'b1;
                    state_n     = WAIT_Z;
                end
            end
            WAIT_Z: begin
                if (fpu_z_stb && fpu_z_ack) begin
                    rsp_z_n              = fpu_z;
                    fpu_z_ack_n          = 1'b0;
                    rsp_stb_n            = '0;
                    rsp_stb_n[grant_idx] = 1'b1;
                    state_n              = DELIVER;
                end
            end
            DELIVER: begin
                if (rsp_stb[grant_idx] && rsp_ack[grant_idx]) begin
                    rsp_stb_n  = '0;
                    last_n     = grant_idx;
                    op_count_n = op_count + CNT_W'(1);
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            grant_idx <= '0;
            req_ack   <= '0;
            rsp_stb   <= '0;
            rsp_z     <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            b_hold    <= '0;
            fpu_a_stb <= 1'b0;
            fpu_b_stb <= 1'b0;
            fpu_z_ack <= 1'b0;
            op_count  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state     <= state_n;
            last      <= last_n;
            grant_idx <= grant_idx_n;
            req_ack   <= req_ack_n;
            rsp_stb   <= rsp_stb_n;
            rsp_z     <= rsp_z_n;
            fpu_a     <= fpu_a_n;
            fpu_b     <= fpu_b_n;
            b_hold    <= b_hold_n;
            fpu_a_stb <= fpu_a_stb_n;
            fpu_b_stb <= fpu_b_stb_n;
            fpu_z_ack <= fpu_z_ack_n;
            op_count  <= op_count_n;
        end
    end

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter; the bench plays the adder and returns
// hand-computed IEEE results for the operands it is handed.
module tb_fpu_add_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]       req_op, req_stb, req_ack;
    logic [WIDTH-1:0]         rsp_z;
    logic [NUM_REQ-1:0]       rsp_stb, rsp_ack;
    logic [WIDTH-1:0]         fpu_a, fpu_b, fpu_z;
    logic                     fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack;
    logic                     fpu_z_stb, fpu_z_ack, busy;
    logic [IDX_W-1:0]         grant_idx;
    logic [CNT_W-1:0]         op_count;

    int compared   = 0;
    int mismatched = 0;
    int exp_cnt    = 0;
    logic [WIDTH-1:0] z_hold;

    fpu_add_arbiter #(
        .WIDTH (WIDTH), .NUM_REQ (NUM_REQ), .IDX_W (IDX_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst),
        .req_a (req_a), .req_b (req_b), .req_op (req_op),
        .req_stb (req_stb), .req_ack (req_ack),
        .rsp_z (rsp_z), .rsp_stb (rsp_stb), .rsp_ack (rsp_ack),
        .fpu_a (fpu_a), .fpu_a_stb (fpu_a_stb), .fpu_a_ack (fpu_a_ack),
        .fpu_b (fpu_b), .fpu_b_stb (fpu_b_stb), .fpu_b_ack (fpu_b_ack),
        .fpu_z (fpu_z), .fpu_z_stb (fpu_z_stb), .fpu_z_ack (fpu_z_ack),
        .busy (busy), .grant_idx (grant_idx), .op_count (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel, input int idx);
        case (sel)
            0:       return req_ack[idx];
            1:       return fpu_a_stb;
            2:       return fpu_b_stb;
            3:       return fpu_z_ack;
            default: return rsp_stb[idx];
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int sel, input int idx);
        int n = 0;
        while (!sig(sel, idx) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel, idx)) check({tag, " timeout"}, 32'(sig(sel, idx)), 32'd1);
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_op[idx]  = op;
        req_stb[idx] = 1'b1;
    endtask

    // Raise a request, wait for its grant, let it transfer, then drop the strobe.
    task automatic submit(input int idx, input logic [31:0] a, input logic [31:0] b, input logic op);
        set_req(idx, a, b, op);
        wait_hi("req_ack", 0, idx);
        check("grant_idx", 32'(grant_idx), 32'(idx));
        @(negedge clk);
        check("req_ack cleared", 32'(req_ack), 32'd0);
        req_stb[idx] = 1'b0;
    endtask

    task automatic serve_ab(input logic [31:0] exp_a, input logic [31:0] exp_b);
        wait_hi("fpu_a_stb", 1, 0);
        check("fpu_a", fpu_a, exp_a);
        fpu_a_ack = 1'b1;
        @(negedge clk);
        fpu_a_ack = 1'b0;
        check("fpu_a_stb cleared", 32'(fpu_a_stb), 32'd0);
        wait_hi("fpu_b_stb", 2, 0);
        check("fpu_b", fpu_b, exp_b);
        fpu_b_ack = 1'b1;
        @(negedge clk);
        fpu_b_ack = 1'b0;
        wait_hi("fpu_z_ack", 3, 0);
    endtask

    task automatic serve_z(input logic [31:0] z);
        fpu_z     = z;
        fpu_z_stb = 1'b1;
        @(negedge clk);
        fpu_z_stb = 1'b0;
        check("fpu_z_ack cleared", 32'(fpu_z_ack), 32'd0);
    endtask

    task automatic collect(input int idx, input logic [31:0] z);
        wait_hi("rsp_stb", 4, idx);
        check("rsp_stb onehot", 32'(rsp_stb), 32'(1) << idx);
        check("rsp_z", rsp_z, z);
        rsp_ack[idx] = 1'b1;
        @(negedge clk);
        rsp_ack[idx] = 1'b0;
        exp_cnt++;
        check("rsp_stb cleared", 32'(rsp_stb), 32'd0);
        check("op_count", 32'(op_count), 32'(exp_cnt));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req_ack"},   32'(req_ack),   32'd0);
        check({tag, " rsp_stb"},   32'(rsp_stb),   32'd0);
        check({tag, " fpu_a_stb"}, 32'(fpu_a_stb), 32'd0);
        check({tag, " fpu_b_stb"}, 32'(fpu_b_stb), 32'd0);
        check({tag, " fpu_z_ack"}, 32'(fpu_z_ack), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " op_count"},  32'(op_count),  32'd0);
        check({tag, " grant_idx"}, 32'(grant_idx), 32'd0);
        check({tag, " fpu_a"},     fpu_a,          32'd0);
        check({tag, " fpu_b"},     fpu_b,          32'd0);
        check({tag, " rsp_z"},     rsp_z,          32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; req_b = '0; req_op = '0; req_stb = '0; rsp_ack = '0;
        fpu_a_ack = 1'b0; fpu_b_ack = 1'b0; fpu_z = '0; fpu_z_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1.0 + 2.0 = 3.0
        submit(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
        serve_ab(32'h3F80_0000, 32'h4000_0000);
        serve_z(32'h4040_0000);
        collect(0, 32'h4040_0000);

        // 1.0 - 1.0: b reaches the adder as -1.0, result +0
        submit(0, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
        serve_ab(32'h3F80_0000, 32'hBF80_0000);
        serve_z(32'h0000_0000);
        collect(0, 32'h0000_0000);

        // +Inf - +Inf: b reaches the adder as -Inf, result is the adder's NaN
        submit(0, 32'h7F80_0000, 32'h7F80_0000, 1'b1);
        serve_ab(32'h7F80_0000, 32'hFF80_0000);
        serve_z(32'hFFC0_0000);
        collect(0, 32'hFFC0_0000);

        // Backpressure on requester 2 while requester 3 waits.
        submit(2, 32'h4040_0000, 32'h3F80_0000, 1'b0);
        serve_ab(32'h4040_0000, 32'h3F80_0000);
        serve_z(32'h4080_0000);
        set_req(3, 32'h4080_0000, 32'h4000_0000, 1'b1);
        wait_hi("rsp_stb", 4, 2);
        rsp_ack[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("hold rsp_stb", 32'(rsp_stb), 32'h4);
            check("hold rsp_z", rsp_z, 32'h4080_0000);
            check("hold req_ack", 32'(req_ack), 32'd0);
            @(negedge clk);
        end
        rsp_ack[1] = 1'b0;
        collect(2, 32'h4080_0000);
        submit(3, 32'h4080_0000, 32'h4000_0000, 1'b1);
        serve_ab(32'h4080_0000, 32'hC000_0000);
        serve_z(32'h4000_0000);
        collect(3, 32'h4000_0000);

        // Withdrawal before transfer returns to idle with no operation.
        set_req(1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        wait_hi("req_ack", 0, 1);
        req_stb[1] = 1'b0;
        @(negedge clk);
        check("withdraw req_ack", 32'(req_ack), 32'd0);
        check("withdraw busy", 32'(busy), 32'd0);
        check("withdraw fpu_a_stb", 32'(fpu_a_stb), 32'd0);
        check("withdraw op_count", 32'(op_count), 32'(exp_cnt));

        // Reset while waiting on the adder result aborts the operation.
        submit(1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        serve_ab(32'h3F80_0000, 32'h3F80_0000);
        rst = 1'b1;
        #1;
        check_idle_outputs("async reset");
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post reset rsp_stb", 32'(rsp_stb), 32'd0);
        submit(1, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        serve_ab(32'h3F80_0000, 32'h3F80_0000);
        serve_z(32'h4000_0000);
        collect(1, 32'h4000_0000);

        // Contention: all strobes high from reset, expected grant order 0,1,2,3,0.
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 32'h4000_0000 | 32'(i), 32'h4100_0000 | 32'(i), i[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NUM_REQ;
            z_hold = 32'h5000_0000 | 32'(k);
            wait_hi("contend req_ack", 0, g);
            check("contend grant_idx", 32'(grant_idx), 32'(g));
            check("contend req_ack", 32'(req_ack), 32'(1) << g);
            serve_ab(32'h4000_0000 | 32'(g),
                     (32'h4100_0000 | 32'(g)) ^ ((g % 2 == 1) ? 32'h8000_0000 : 32'h0));
            serve_z(z_hold);
            collect(g, z_hold);
        end
        req_stb = '0;
        @(negedge clk);
        @(negedge clk);
        check("final busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one fpu_adder instance among NUM_REQ requesters.
- Each requester submits an (a, b, op) triple over a strobe/ack handshake and receives its IEEE sum or difference back.
- A round-robin arbiter picks requesters; an FSM sequences the adder's get_a, get_b and put_z handshakes.
- Sits between requester logic and the adder's input_a/input_b/output_z ports.

Parameters:
- WIDTH, 32, float word width; must match the adder's `WIDTH.
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, 2, grant index width, equal to clog2(NUM_REQ).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_a  in  NUM_REQ*WIDTH  packed operand A, slice i belongs to requester i.
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- req_op  in  NUM_REQ  per-requester op: 0 = add, 1 = subtract (a - b).
- req_stb  in  NUM_REQ  per-requester request strobe.
- req_ack  out  NUM_REQ  per-requester request acknowledge.
- rsp_z  out  WIDTH  result bus, shared by all requesters.
- rsp_stb  out  NUM_REQ  result valid; one-hot or zero.
- rsp_ack  in  NUM_REQ  result accept.
- fpu_a  out  WIDTH  to adder input_a.
- fpu_a_stb  out  1  to adder input_a_stb.
- fpu_a_ack  in  1  from adder input_a_ack.
- fpu_b  out  WIDTH  to adder input_b.
- fpu_b_stb  out  1  to adder input_b_stb.
- fpu_b_ack  in  1  from adder input_b_ack.
- fpu_z  in  WIDTH  from adder output_z.
- fpu_z_stb  in  1  from adder output_z_stb.
- fpu_z_ack  out  1  to adder output_z_ack.
- busy  out  1  high in every state except IDLE.
- grant_idx  out  IDX_W  index of the current or last granted requester.
- op_count  out  CNT_W  number of completed operations; wraps modulo 2^CNT_W.

Behaviour:
- Handshake rule on every channel: a transfer happens on a clk edge where stb and ack are both high.
  - stb holds its data stable until that edge.
  - All outputs are registered; there are no combinational input-to-output paths.
- Reset (asynchronous): state = IDLE; every stb/ack output = 0; rsp_z = 0; fpu_a = fpu_b = 0; op_count = 0; grant_idx = 0; rr pointer last = NUM_REQ-1, so requester 0 wins first.
  - The adder's synchronous rst is driven by the same net, so rst is held for at least one clk edge.
  - Reset mid-operation aborts the operation: no rsp_stb is issued and the counter does not increment.
- IDLE: if any req_stb is high, grant g = first asserted index scanning last+1, last+2, ... cyclically.
  - Register g into grant_idx, set req_ack[g] = 1, go to ACCEPT.
- ACCEPT:
  - On req_stb[g] && req_ack[g]: capture a and b; if op = 1, invert b[WIDTH-1]; clear req_ack[g]; load fpu_a; set fpu_a_stb = 1; go to SEND_A.
  - If req_stb[g] drops first (withdrawal): clear req_ack[g] and return to IDLE; the pointer is unchanged.
- SEND_A: on fpu_a_stb && fpu_a_ack, clear fpu_a_stb, load fpu_b, set fpu_b_stb = 1, go to SEND_B.
- SEND_B: on fpu_b_stb && fpu_b_ack, clear fpu_b_stb, set fpu_z_ack = 1, go to WAIT_Z.
- WAIT_Z: on fpu_z_stb && fpu_z_ack, capture fpu_z into rsp_z, clear fpu_z_ack, set rsp_stb[g] = 1, go to DELIVER.
- DELIVER: on rsp_stb[g] && rsp_ack[g], clear rsp_stb[g], set last = g, op_count += 1, go to IDLE.
  - rsp_z holds until the next result is captured.
- Exactly one operation is in flight at a time; later requests wait with req_ack low.
- Block overhead is 4 cycles (IDLE, ACCEPT, DELIVER, plus 1), on top of adder latency and handshake waits.
- Simultaneous requests are resolved by rr priority only. A requester re-requesting right after its own completion has the lowest priority.
- rsp_ack on a non-granted index is ignored. req_stb changes on non-granted indices have no effect.
- Sign inversion for subtract is also applied to NaN and Inf operands; the adder's special-case rules then apply unmodified.

Decomposition:
- Shared include (fpu_defs): WIDTH/EXPONENT/MANTISSA defines (existing), FSM state encodings IDLE=0, ACCEPT=1, SEND_A=2, SEND_B=3, WAIT_Z=4, DELIVER=5, and the OP_ADD/OP_SUB constants.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector and last pointer.
  - Outputs: grant index and any-valid.
- The FSM, operand muxing and counter stay in fpu_add_arbiter.

Test Plan:
- Single add: req 0 sends a = 0x3F800000, b = 0x40000000, op = 0 -> rsp_stb[0] with rsp_z = 0x40400000; op_count = 1.
- Subtract to zero: a = 0x3F800000, b = 0x3F800000, op = 1 -> rsp_z = 0x00000000 (positive zero).
- Inf minus Inf: a = 0x7F800000, b = 0x7F800000, op = 1 -> rsp_z = 0xFFC00000.
- Contention: all 4 req_stb asserted continuously from reset -> grant order 0,1,2,3,0; each rsp_stb is one-hot on the matching index.
- Backpressure: rsp_ack[2] held low for 20 cycles with req 3 pending -> rsp_stb[2] and rsp_z stable, req_ack[3] stays 0; req 3 is served only after rsp_ack[2].
- Reset in WAIT_Z: all stb/ack outputs are 0 immediately (asynchronous), with no rsp_stb and op_count = 0. The next request completes correctly.
